// File: rtl/wdata_burst_sender_pkg.sv
// Shared definitions for the write-data burst sender: state encoding,
// burst length and write-data width.
package wdata_burst_sender_pkg;

  // Write-data path width, shared with the write-data FIFO.
  localparam int unsigned WdataW = 128;

  // Beats per DRAM write burst.
  localparam int unsigned BurstLen = 8;

  // Width of the programmed write-latency field.
  localparam int unsigned WlW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StBurst = 2'd2
  } state_e;

  // True when n is a power of two and at least 2.
  function automatic bit is_valid_bl(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/wdata_burst_sender.sv
// Pops one burst of write data from an FWFT FIFO a programmed number of cycles
// after a write command and drives it as registered beats toward the DQ path.
module wdata_burst_sender
  import wdata_burst_sender_pkg::*;
#(
  parameter int unsigned DATA_W = WdataW,
  parameter int unsigned BL     = BurstLen,
  parameter int unsigned WL_W   = WlW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_issue,
  input  logic [WL_W-1:0]   wl,
  output logic              issue_ready,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_ren,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              burst_done,
  output logic              busy,
  output logic              underrun,
  output logic              proto_err
);

  localparam int unsigned BeatW = $clog2(BL);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BL - 1);

  if (!is_valid_bl(BL)) begin : g_bl_check
    $error("BL must be a power of two and at least 2");
  end

  state_e            state_q;
  logic [WL_W-1:0]   wait_cnt_q;
  logic [BeatW-1:0]  beat_cnt_q;
  logic [DATA_W-1:0] dq_out_q;
  logic              dq_oe_q;
  logic              burst_done_q;
  logic              underrun_q;
  logic              proto_err_q;
  logic [WL_W-1:0]   wait_load;
  logic              in_burst;

  // wl = 0 behaves like wl = 1, so the load value is max(wl,1) - 1.
  assign wait_load = (wl == '0) ? '0 : wl - WL_W'(1);
  assign in_burst  = (state_q == StBurst);

  // Burst sequencing, output register and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      burst_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      // A command while not idle is dropped; the burst in flight continues.
      if (wr_issue && (state_q != StIdle)) begin
        proto_err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          dq_oe_q  <= 1'b0;
          dq_out_q <= '0;
          if (wr_issue) begin
            wait_cnt_q <= wait_load;
            beat_cnt_q <= '0;
            state_q    <= (wait_load == '0) ? StBurst : StWait;
          end
        end
        StWait: begin
          dq_oe_q    <= 1'b0;
          dq_out_q   <= '0;
          wait_cnt_q <= wait_cnt_q - WL_W'(1);
          if (wait_cnt_q == WL_W'(1)) begin
            state_q <= StBurst;
          end
        end
        StBurst: begin
          // An empty FIFO still yields a beat (zero data) to keep DRAM timing.
          dq_oe_q    <= 1'b1;
          dq_out_q   <= fifo_empty ? '0 : fifo_data;
          beat_cnt_q <= beat_cnt_q + BeatW'(1);
          if (fifo_empty) begin
            underrun_q <= 1'b1;
          end
          if (beat_cnt_q == LastBeat) begin
            state_q      <= StIdle;
            burst_done_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          dq_oe_q  <= 1'b0;
          dq_out_q <= '0;
        end
      endcase
    end
  end

  assign fifo_ren    = in_burst && !fifo_empty;
  assign issue_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign burst_done  = burst_done_q;
  assign proto_err   = proto_err_q;
  // Flag is visible in the very cycle a beat finds the FIFO empty.
  assign underrun    = underrun_q | (in_burst && fifo_empty);

  // The last-beat pulse always coincides with a driven beat.
  a_done_with_beat: assert property (@(posedge clk) disable iff (!rst_n)
    burst_done |-> dq_oe);

endmodule

// File: tb/tb_wdata_burst_sender.sv
// Directed bench for wdata_burst_sender with a small FWFT FIFO model.
module tb_wdata_burst_sender;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_issue;
  logic [3:0]   wl;
  logic         issue_ready;
  logic         fifo_empty;
  logic [127:0] fifo_data;
  logic         fifo_ren;
  logic [127:0] dq_out;
  logic         dq_oe;
  logic         burst_done;
  logic         busy;
  logic         underrun;
  logic         proto_err;

  int total = 0;
  int bad   = 0;

  // FWFT FIFO model: initial block pushes, DUT pops on posedge.
  logic [127:0] mem [0:255];
  logic [7:0]   wr_ptr = '0;
  logic [7:0]   rd_ptr = '0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_ren) rd_ptr <= rd_ptr + 8'd1;
  end

  always #5 clk = ~clk;

  wdata_burst_sender #(
    .DATA_W(128),
    .BL    (8),
    .WL_W  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_issue   (wr_issue),
    .wl         (wl),
    .issue_ready(issue_ready),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_ren   (fifo_ren),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe),
    .burst_done (burst_done),
    .busy       (busy),
    .underrun   (underrun),
    .proto_err  (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    wr_issue = 1'b0;
    wl       = 4'd0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] got;
    got = {fifo_ren, dq_oe, burst_done, busy, issue_ready, underrun, proto_err};
    total++;
    if (got !== 7'b0000100) begin
      bad++;
      $display("FAIL reset_ctl got %b want %b", got, 7'b0000100);
    end
    total++;
    if (dq_out !== 128'd0) begin
      bad++;
      $display("FAIL reset_dq got %h want 0", dq_out);
    end
  endtask

  // One 8-beat burst with all data present; k counts cycles from the issue.
  task automatic test_latency(input logic [3:0] wl_in, input logic [127:0] base,
                              input bit do_push);
    int           we;
    logic [4:0]   exp_v;
    logic [4:0]   got_v;
    logic [127:0] exp_dq;
    logic [2:0]   got_end;
    we = (wl_in == 4'd0) ? 1 : int'(wl_in);
    if (do_push) for (int i = 0; i < 8; i++) push(base + 128'(i));
    for (int k = 0; k <= we + 9; k++) begin
      wr_issue = (k == 0);
      wl       = wl_in;
      @(negedge clk);
      exp_v  = {(k >= we && k <= we + 7), (k >= we + 1 && k <= we + 8), (k == we + 8),
                (k >= 1 && k <= we + 7), !(k >= 1 && k <= we + 7)};
      exp_dq = (k >= we + 1 && k <= we + 8) ? base + 128'(k - we - 1) : 128'd0;
      got_v  = {fifo_ren, dq_oe, burst_done, busy, issue_ready};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL lat%0d_ctl k=%0d got %b want %b", wl_in, k, got_v, exp_v);
      end
      total++;
      if (dq_out !== exp_dq) begin
        bad++;
        $display("FAIL lat%0d_dq k=%0d got %h want %h", wl_in, k, dq_out, exp_dq);
      end
      tick();
    end
    wr_issue = 1'b0;
    got_end  = {fifo_empty, underrun, proto_err};
    total++;
    if (got_end !== 3'b100) begin
      bad++;
      $display("FAIL lat%0d_end got %b want %b", wl_in, got_end, 3'b100);
    end
  endtask

  // Five entries for an 8-beat burst: last three beats are zero, underrun sticks.
  task automatic test_underrun();
    logic [5:0]   exp_v;
    logic [5:0]   got_v;
    logic [127:0] exp_dq;
    for (int i = 0; i < 5; i++) push(128'hB0 + 128'(i));
    for (int k = 0; k <= 13; k++) begin
      wr_issue = (k == 0);
      wl       = 4'd3;
      @(negedge clk);
      exp_v  = {(k >= 3 && k <= 7), (k >= 4 && k <= 11), (k == 11),
                (k >= 1 && k <= 10), !(k >= 1 && k <= 10), (k >= 8)};
      exp_dq = (k >= 4 && k <= 8) ? 128'hB0 + 128'(k - 4) : 128'd0;
      got_v  = {fifo_ren, dq_oe, burst_done, busy, issue_ready, underrun};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL underrun_ctl k=%0d got %b want %b", k, got_v, exp_v);
      end
      total++;
      if (dq_out !== exp_dq) begin
        bad++;
        $display("FAIL underrun_dq k=%0d got %h want %h", k, dq_out, exp_dq);
      end
      tick();
    end
    wr_issue = 1'b0;
  endtask

  // Extra commands in WAIT (k=2) and BURST (k=6) are dropped.
  task automatic test_proto();
    logic [5:0]   exp_v;
    logic [5:0]   got_v;
    logic [127:0] exp_dq;
    for (int i = 0; i < 8; i++) push(128'hC0 + 128'(i));
    for (int k = 0; k <= 16; k++) begin
      wr_issue = (k == 0) || (k == 2) || (k == 6);
      wl       = 4'd4;
      @(negedge clk);
      exp_v  = {(k >= 4 && k <= 11), (k >= 5 && k <= 12), (k == 12),
                (k >= 1 && k <= 11), !(k >= 1 && k <= 11), (k >= 3)};
      exp_dq = (k >= 5 && k <= 12) ? 128'hC0 + 128'(k - 5) : 128'd0;
      got_v  = {fifo_ren, dq_oe, burst_done, busy, issue_ready, proto_err};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL proto_ctl k=%0d got %b want %b", k, got_v, exp_v);
      end
      total++;
      if (dq_out !== exp_dq) begin
        bad++;
        $display("FAIL proto_dq k=%0d got %h want %h", k, dq_out, exp_dq);
      end
      tick();
    end
    wr_issue = 1'b0;
    total++;
    if (rd_ptr !== wr_ptr) begin
      bad++;
      $display("FAIL proto_pops got rd=%0d want %0d", rd_ptr, wr_ptr);
    end
  endtask

  // Second issue lands on the first cycle issue_ready is back (k=10).
  task automatic test_back_to_back();
    logic [5:0]   exp_v;
    logic [5:0]   got_v;
    logic [127:0] exp_dq;
    for (int i = 0; i < 16; i++) push(128'(i));
    for (int k = 0; k <= 22; k++) begin
      wr_issue = (k == 0) || (k == 10);
      wl       = 4'd2;
      @(negedge clk);
      exp_v = {(k >= 2 && k <= 9) || (k >= 12 && k <= 19),
               (k >= 3 && k <= 10) || (k >= 13 && k <= 20),
               (k == 10) || (k == 20),
               (k >= 1 && k <= 9) || (k >= 11 && k <= 19),
               !((k >= 1 && k <= 9) || (k >= 11 && k <= 19)),
               1'b0};
      if (k >= 3 && k <= 10)       exp_dq = 128'(k - 3);
      else if (k >= 13 && k <= 20) exp_dq = 128'(k - 5);
      else                         exp_dq = 128'd0;
      got_v = {fifo_ren, dq_oe, burst_done, busy, issue_ready, proto_err};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL b2b_ctl k=%0d got %b want %b", k, got_v, exp_v);
      end
      total++;
      if (dq_out !== exp_dq) begin
        bad++;
        $display("FAIL b2b_dq k=%0d got %h want %h", k, dq_out, exp_dq);
      end
      tick();
    end
    wr_issue = 1'b0;
  endtask

  // Reset mid-burst after three pops, between clock edges, then resume.
  task automatic test_async_reset();
    logic [6:0] got;
    for (int i = 0; i < 8; i++) push(128'hA0 + 128'(i));
    for (int k = 0; k <= 4; k++) begin
      wr_issue = (k == 0);
      wl       = 4'd2;
      tick();
    end
    wr_issue = 1'b0;
    total++;
    if (dq_oe !== 1'b1 || dq_out !== 128'hA2) begin
      bad++;
      $display("FAIL arst_pre got oe=%b dq=%h want oe=1 dq=a2", dq_oe, dq_out);
    end
    #1;
    rst_n = 1'b0;
    #1;
    got = {fifo_ren, dq_oe, burst_done, busy, issue_ready, underrun, proto_err};
    total++;
    if (got !== 7'b0000100) begin
      bad++;
      $display("FAIL arst_ctl got %b want %b", got, 7'b0000100);
    end
    total++;
    if (dq_out !== 128'd0) begin
      bad++;
      $display("FAIL arst_dq got %h want 0", dq_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (rd_ptr !== 8'(wr_ptr - 8'd5)) begin
      bad++;
      $display("FAIL arst_pops got rd=%0d want %0d", rd_ptr, wr_ptr - 8'd5);
    end
    for (int i = 8; i < 11; i++) push(128'hA0 + 128'(i));
    test_latency(4'd5, 128'hA3, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_issue = 1'b0;
    wl       = 4'd0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_latency(4'd5, 128'hA0, 1'b1);
    test_latency(4'd0, 128'h10, 1'b1);
    test_latency(4'd1, 128'h20, 1'b1);
    do_reset();
    test_underrun();
    do_reset();
    test_proto();
    do_reset();
    test_back_to_back();
    do_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
